// File: rtl/wb_stage_pkg.sv
// Shared definitions for the writeback stage: result-source codes, load funct3 codes,
// FSM state encoding and default bus widths.
package wb_stage_pkg;

  // Default register-file bus widths.
  localparam int unsigned RegBusW  = 32;
  localparam int unsigned RegAddrW = 5;

  // Result source selection carried down from MEM.
  localparam logic [1:0] WbSelAlu  = 2'd0;
  localparam logic [1:0] WbSelLoad = 2'd1;
  localparam logic [1:0] WbSelPc4  = 2'd2;
  localparam logic [1:0] WbSelNone = 2'd3;

  // Load type encodings (RV32I funct3). Codes 3, 6 and 7 are illegal.
  localparam logic [2:0] F3Lb  = 3'd0;
  localparam logic [2:0] F3Lh  = 3'd1;
  localparam logic [2:0] F3Lw  = 3'd2;
  localparam logic [2:0] F3Lbu = 3'd4;
  localparam logic [2:0] F3Lhu = 3'd5;

  typedef enum logic [1:0] {
    StIdle,
    StWaitLoad,
    StCommit,
    StDrain
  } wb_state_e;

  // True when the instruction must wait for a data-memory response.
  function automatic logic is_load_sel(input logic [1:0] sel);
    return sel == WbSelLoad;
  endfunction

endpackage

// File: rtl/wb_stage_load_align.sv
// Load data alignment: picks the addressed byte/halfword out of the 32-bit memory word,
// sign- or zero-extends it, and flags misaligned accesses and illegal load types.
module load_align
  import wb_stage_pkg::*;
#(
  parameter int unsigned XLEN = RegBusW
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      byte_off,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] data,
  output logic            err
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata[{byte_off, 3'b000} +: 8];
  // Halfword lane is chosen by off[1] only; off[0] set is reported as misaligned.
  assign half_sel = rdata[{byte_off[1], 4'b0000} +: 16];

  // Extend the selected lane and flag bad offsets / funct3 values.
  always_comb begin
    data = '0;
    err  = 1'b0;
    unique case (funct3)
      F3Lb:    data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3Lbu:   data = {{(XLEN-8){1'b0}}, byte_sel};
      F3Lh: begin
        data = {{(XLEN-16){half_sel[15]}}, half_sel};
        err  = byte_off[0];
      end
      F3Lhu: begin
        data = {{(XLEN-16){1'b0}}, half_sel};
        err  = byte_off[0];
      end
      F3Lw: begin
        data = rdata;
        err  = |byte_off;
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: accepts one retiring instruction per handshake, waits for the load
// response when needed, and drives registered RegFile write signals plus a retire counter.
// Non-loads commit on the accepting edge, so COMMIT is the cycle the write is visible and
// the stage is already ready for the next instruction.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int unsigned XLEN         = RegBusW,
  parameter int unsigned REG_ADDR_W   = RegAddrW,
  parameter int unsigned LOAD_TIMEOUT = 64
) (
  input  logic                  sys_clk,
  input  logic                  rstn,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic                  mem_reg_write,
  input  logic [REG_ADDR_W-1:0] mem_rd_addr,
  input  logic [1:0]            mem_wb_sel,
  input  logic [XLEN-1:0]       mem_alu_result,
  input  logic [XLEN-1:0]       mem_pc_plus4,
  input  logic [2:0]            mem_load_funct3,
  input  logic                  flush,
  input  logic                  dmem_rvalid,
  input  logic [XLEN-1:0]       dmem_rdata,
  output logic [REG_ADDR_W-1:0] WriteAddr,
  output logic [XLEN-1:0]       WriteData,
  output logic                  RegWrite,
  output logic                  load_err,
  output logic [31:0]           retire_cnt
);

  localparam int unsigned CntW = (LOAD_TIMEOUT > 1) ? $clog2(LOAD_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(LOAD_TIMEOUT - 1);

  wb_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Load instruction held while its response is outstanding.
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  we_q;
  logic [2:0]            funct3_q;
  logic [1:0]            off_q;

  logic                  accept;
  logic                  cnt_done;
  logic                  commit;
  logic                  commit_we;
  logic                  commit_err;
  logic                  timeout_err;
  logic [REG_ADDR_W-1:0] commit_addr;
  logic [XLEN-1:0]       commit_data;
  logic [XLEN-1:0]       align_data;
  logic                  align_err;

  logic [REG_ADDR_W-1:0] write_addr_q;
  logic [XLEN-1:0]       write_data_q;
  logic                  reg_write_q;
  logic                  load_err_q;
  logic [31:0]           retire_q;

  load_align #(
    .XLEN (XLEN)
  ) u_load_align (
    .rdata    (dmem_rdata),
    .byte_off (off_q),
    .funct3   (funct3_q),
    .data     (align_data),
    .err      (align_err)
  );

  assign mem_ready = (state_q == StIdle) || (state_q == StCommit);
  assign accept    = mem_valid & mem_ready & ~flush;
  assign cnt_done  = (cnt_q == CntLast);

  // FSM state register.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and wait counter; the counter restarts on every state change.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StCommit: begin
        if (accept) begin
          state_d = is_load_sel(mem_wb_sel) ? StWaitLoad : StCommit;
        end else begin
          state_d = StIdle;
        end
      end
      StWaitLoad: begin
        // A response arriving with the flush is consumed, so nothing is left to drain.
        if (flush) begin
          state_d = dmem_rvalid ? StIdle : StDrain;
        end else if (dmem_rvalid) begin
          state_d = StCommit;
        end else if (cnt_done) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        // Bounded so a response that never arrives cannot wedge the stage.
        if (dmem_rvalid || cnt_done) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    cnt_d = '0;
    if (((state_q == StWaitLoad) || (state_q == StDrain)) && (state_d == state_q)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Commit decision and write source for the current cycle.
  always_comb begin
    commit      = 1'b0;
    commit_err  = 1'b0;
    timeout_err = 1'b0;
    commit_addr = mem_rd_addr;
    commit_data = (mem_wb_sel == WbSelPc4) ? mem_pc_plus4 : mem_alu_result;
    commit_we   = mem_reg_write & (mem_wb_sel != WbSelNone);
    unique case (state_q)
      StIdle, StCommit: begin
        commit = accept & ~is_load_sel(mem_wb_sel);
      end
      StWaitLoad: begin
        commit      = dmem_rvalid & ~flush;
        commit_addr = rd_q;
        commit_data = align_data;
        commit_err  = align_err;
        commit_we   = we_q & ~align_err;
        timeout_err = ~dmem_rvalid & ~flush & cnt_done;
      end
      default: ;
    endcase
    commit_we = commit_we & (commit_addr != '0);
  end

  // Registered RegFile interface, error pulse, retire counter and load capture.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      reg_write_q  <= 1'b0;
      load_err_q   <= 1'b0;
      write_addr_q <= '0;
      write_data_q <= '0;
      retire_q     <= '0;
      rd_q         <= '0;
      we_q         <= 1'b0;
      funct3_q     <= '0;
      off_q        <= '0;
    end else begin
      reg_write_q <= commit & commit_we;
      load_err_q  <= (commit & commit_err) | timeout_err;
      if (commit & commit_we) begin
        write_addr_q <= commit_addr;
        write_data_q <= commit_data;
      end
      if (commit) begin
        retire_q <= retire_q + 32'd1;
      end
      if (accept) begin
        rd_q     <= mem_rd_addr;
        we_q     <= mem_reg_write;
        funct3_q <= mem_load_funct3;
        off_q    <= mem_alu_result[1:0];
      end
    end
  end

  assign WriteAddr  = write_addr_q;
  assign WriteData  = write_data_q;
  assign RegWrite   = reg_write_q;
  assign load_err   = load_err_q;
  assign retire_cnt = retire_q;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios followed by random transactions,
// every cycle compared against a transaction-level model kept in the bench.
module tb_wb_stage;
  import wb_stage_pkg::*;

  localparam int unsigned Xlen    = 32;
  localparam int unsigned AddrW   = 5;
  localparam int unsigned Timeout = 8;

  logic             sys_clk = 1'b0;
  logic             rstn    = 1'b0;
  logic             mem_valid;
  logic             mem_ready;
  logic             mem_reg_write;
  logic [AddrW-1:0] mem_rd_addr;
  logic [1:0]       mem_wb_sel;
  logic [Xlen-1:0]  mem_alu_result;
  logic [Xlen-1:0]  mem_pc_plus4;
  logic [2:0]       mem_load_funct3;
  logic             flush;
  logic             dmem_rvalid;
  logic [Xlen-1:0]  dmem_rdata;
  logic [AddrW-1:0] WriteAddr;
  logic [Xlen-1:0]  WriteData;
  logic             RegWrite;
  logic             load_err;
  logic [31:0]      retire_cnt;

  always #5 sys_clk = ~sys_clk;

  wb_stage #(
    .XLEN         (Xlen),
    .REG_ADDR_W   (AddrW),
    .LOAD_TIMEOUT (Timeout)
  ) dut (
    .sys_clk         (sys_clk),
    .rstn            (rstn),
    .mem_valid       (mem_valid),
    .mem_ready       (mem_ready),
    .mem_reg_write   (mem_reg_write),
    .mem_rd_addr     (mem_rd_addr),
    .mem_wb_sel      (mem_wb_sel),
    .mem_alu_result  (mem_alu_result),
    .mem_pc_plus4    (mem_pc_plus4),
    .mem_load_funct3 (mem_load_funct3),
    .flush           (flush),
    .dmem_rvalid     (dmem_rvalid),
    .dmem_rdata      (dmem_rdata),
    .WriteAddr       (WriteAddr),
    .WriteData       (WriteData),
    .RegWrite        (RegWrite),
    .load_err        (load_err),
    .retire_cnt      (retire_cnt)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  // Model of what the outputs must show after the next clock edge.
  logic             exp_we;
  logic             exp_err;
  logic             exp_ready;
  logic [AddrW-1:0] exp_addr;
  logic [31:0]      exp_data;
  logic [31:0]      exp_retire;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference load result computed from the word with shifts and masks.
  function automatic logic [31:0] load_ref(input logic [31:0] word, input int off, input int f3,
                                           output logic err);
    logic [31:0] sh;
    logic [31:0] v;
    sh  = word >> (8 * off);
    err = 1'b0;
    v   = 32'd0;
    case (f3)
      0: begin
        v = sh & 32'hFF;
        if (v >= 32'h80) v = v | 32'hFFFF_FF00;
      end
      4: v = sh & 32'hFF;
      1: begin
        err = (off % 2) != 0;
        v   = sh & 32'hFFFF;
        if (v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
      5: begin
        err = (off % 2) != 0;
        v   = sh & 32'hFFFF;
      end
      2: begin
        err = off != 0;
        v   = word;
      end
      default: err = 1'b1;
    endcase
    return v;
  endfunction

  task automatic model_reset();
    exp_we     = 1'b0;
    exp_err    = 1'b0;
    exp_ready  = 1'b1;
    exp_addr   = '0;
    exp_data   = '0;
    exp_retire = '0;
  endtask

  task automatic drive(input logic v, input logic fl, input logic rv, input logic [31:0] rdat);
    mem_valid   = v;
    flush       = fl;
    dmem_rvalid = rv;
    dmem_rdata  = rdat;
  endtask

  task automatic set_inst(input logic [4:0] rd, input logic we, input logic [1:0] sel,
                          input logic [31:0] alu, input logic [31:0] pc, input logic [2:0] f3);
    mem_rd_addr     = rd;
    mem_reg_write   = we;
    mem_wb_sel      = sel;
    mem_alu_result  = alu;
    mem_pc_plus4    = pc;
    mem_load_funct3 = f3;
  endtask

  task automatic check_outputs();
    check_value("reg_write", 32'(RegWrite), 32'(exp_we));
    check_value("load_err", 32'(load_err), 32'(exp_err));
    check_value("mem_ready", 32'(mem_ready), 32'(exp_ready));
    check_value("retire_cnt", retire_cnt, exp_retire);
    check_value("write_addr", 32'(WriteAddr), 32'(exp_addr));
    check_value("write_data", WriteData, exp_data);
  endtask

  // Advance one clock and compare every output with the model; pulses then fall.
  task automatic cycle();
    @(posedge sys_clk);
    #1;
    check_outputs();
    exp_we  = 1'b0;
    exp_err = 1'b0;
  endtask

  task automatic expect_commit(input logic [4:0] rd, input logic we, input logic [31:0] val);
    exp_retire = exp_retire + 32'd1;
    if (we && rd != 5'd0) begin
      exp_we   = 1'b1;
      exp_addr = rd;
      exp_data = val;
    end
  endtask

  // Idle cycle: either nothing offered or an offer blocked by flush; stray rvalid ignored.
  task automatic quiet();
    logic v;
    v = 1'($urandom_range(0, 1));
    drive(v, v ? 1'b1 : 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
    exp_ready = 1'b1;
    cycle();
  endtask

  // Cycle while busy: offers are refused, no response.
  task automatic wait_cycle();
    drive(1'($urandom_range(0, 1)), 1'b0, 1'b0, $urandom);
    exp_ready = 1'b0;
    cycle();
  endtask

  task automatic do_alu(input logic [4:0] rd, input logic we, input logic [1:0] sel,
                        input logic [31:0] alu, input logic [31:0] pc);
    set_inst(rd, we, sel, alu, pc, 3'($urandom_range(0, 7)));
    drive(1'b1, 1'b0, 1'($urandom_range(0, 1)), $urandom);
    expect_commit(rd, we && (sel != 2'd3), (sel == 2'd2) ? pc : alu);
    exp_ready = 1'b1;
    cycle();
  endtask

  task automatic accept_load(input logic [4:0] rd, input logic we, input logic [2:0] f3,
                             input logic [31:0] addr);
    set_inst(rd, we, 2'd1, addr, $urandom, f3);
    drive(1'b1, 1'b0, 1'($urandom_range(0, 1)), $urandom);
    exp_ready = 1'b0;
    cycle();
  endtask

  // Response arrives in the delay-th waiting cycle after the accept.
  task automatic do_load(input logic [4:0] rd, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] word, input int delay);
    logic        err;
    logic [31:0] val;
    accept_load(rd, we, f3, addr);
    for (int i = 1; i < delay; i++) wait_cycle();
    val = load_ref(word, int'(addr & 32'd3), int'(f3), err);
    drive(1'($urandom_range(0, 1)), 1'b0, 1'b1, word);
    expect_commit(rd, we && !err, val);
    exp_err   = err;
    exp_ready = 1'b1;
    cycle();
  endtask

  // Discard phase: the late response arrives in cycle j, or the wait gives up after Timeout.
  task automatic drain(input int j);
    for (int i = 1; i <= int'(Timeout); i++) begin
      if (i == j) begin
        drive(1'($urandom_range(0, 1)), 1'b0, 1'b1, $urandom);
        exp_ready = 1'b1;
        cycle();
        return;
      end
      drive(1'($urandom_range(0, 1)), 1'b0, 1'b0, $urandom);
      exp_ready = (i == int'(Timeout));
      cycle();
    end
  endtask

  task automatic do_flush_load(input int k, input logic with_rv, input int j);
    accept_load(5'($urandom_range(0, 31)), 1'b1, 3'($urandom_range(0, 7)), $urandom);
    for (int i = 1; i < k; i++) wait_cycle();
    drive(1'b1, 1'b1, with_rv, $urandom);
    exp_ready = with_rv;
    cycle();
    if (!with_rv) drain(j);
  endtask

  task automatic do_timeout(input int j);
    accept_load(5'($urandom_range(1, 31)), 1'b1, F3Lw, 32'h0000_0100);
    for (int i = 1; i < int'(Timeout); i++) wait_cycle();
    exp_err = 1'b1;
    wait_cycle();
    drain(j);
  endtask

  task automatic reset_mid_load();
    accept_load(5'd12, 1'b1, F3Lw, 32'h0000_0040);
    wait_cycle();
    wait_cycle();
    drive(1'b0, 1'b0, 1'b0, '0);
    rstn = 1'b0;
    #1;
    model_reset();
    check_outputs();
    #2;
    rstn = 1'b1;
    // The stale response after reset must be ignored.
    drive(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    exp_ready = 1'b1;
    cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_inst('0, 1'b0, 2'd0, '0, '0, '0);
    drive(1'b0, 1'b0, 1'b0, '0);
    model_reset();
    #12;
    check_outputs();
    rstn = 1'b1;

    // Single ALU op.
    do_alu(5'd5, 1'b1, 2'd0, 32'h1234_5678, 32'h0);
    quiet();
    // LB / LBU at offset 3, response four cycles after accept.
    do_load(5'd7, 1'b1, F3Lb, 32'h0000_1003, 32'h80FF_0000, 4);
    quiet();
    do_load(5'd8, 1'b1, F3Lbu, 32'h0000_1003, 32'h80FF_0000, 4);
    // Back-to-back ALU ops, PC+4 link, then rd=0.
    do_alu(5'd1, 1'b1, 2'd0, 32'hAAAA_0001, 32'h0);
    do_alu(5'd2, 1'b1, 2'd2, 32'hAAAA_0002, 32'h0000_2004);
    do_alu(5'd3, 1'b1, 2'd0, 32'hAAAA_0003, 32'h0);
    do_alu(5'd0, 1'b1, 2'd0, 32'hBBBB_0000, 32'h0);
    quiet();
    // Misaligned LW, signed LH, illegal funct3.
    do_load(5'd9, 1'b1, F3Lw, 32'h0000_2002, 32'h1122_3344, 2);
    do_load(5'd10, 1'b1, F3Lh, 32'h0000_2002, 32'h9ABC_1234, 1);
    do_load(5'd11, 1'b1, 3'd6, 32'h0000_2000, 32'h5555_5555, 3);
    quiet();
    // Flush while waiting, response two cycles later; then flush coinciding with rvalid.
    do_flush_load(1, 1'b0, 2);
    do_flush_load(3, 1'b1, 0);
    quiet();
    // Timeout with a late response, then with none at all.
    do_timeout(3);
    quiet();
    do_timeout(int'(Timeout) + 2);
    // Response in the last allowed waiting cycle still commits.
    do_load(5'd13, 1'b1, F3Lhu, 32'h0000_3002, 32'hF00D_CAFE, int'(Timeout));
    reset_mid_load();
    quiet();

    for (int it = 0; it < 400; it++) begin
      int          kind;
      logic [1:0]  sel;
      logic [4:0]  rd;
      rd   = 5'($urandom_range(0, 31));
      kind = int'($urandom_range(0, 9));
      case (kind)
        0, 1, 2: begin
          sel = 2'($urandom_range(0, 3));
          if (sel == 2'd1) sel = 2'd0;
          do_alu(rd, 1'($urandom_range(0, 1)), sel, $urandom, $urandom);
        end
        3, 4: do_load(rd, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                      $urandom, int'($urandom_range(1, Timeout)));
        5: do_flush_load(int'($urandom_range(1, Timeout)), 1'($urandom_range(0, 1)),
                         int'($urandom_range(1, Timeout + 3)));
        6: do_timeout(int'($urandom_range(1, Timeout + 3)));
        default: quiet();
      endcase
    end
    quiet();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
